// File: rtl/wormy_pkg.sv
// wormy_pkg: shared direction encoding and helpers for the worm heading logic
package wormy_pkg;
   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   // Opposite directions share the axis bit and differ in the sense bit
   function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction
endpackage

// File: rtl/heading_debounce.sv
// heading_debounce: filters the decoder pair and emits one press per stable hold
module heading_debounce
   import wormy_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pushed,
   input  logic [1:0] state,
   output logic       press,
   output logic [1:0] press_dir
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic [2:0]       in;
   logic [2:0]       cand;
   logic             stable_pushed;
   logic [CNT_W-1:0] cnt;
   assign in        = {pushed, state};
   assign press     = (in == cand) && (cnt == LAST) && cand[2] && !stable_pushed;
   assign press_dir = cand[1:0];
   // Restart on any input change; once stable long enough, keep re-committing the candidate
   always_ff @(posedge clk)
      if (!rst_n) begin
         cand          <= '0;
         stable_pushed <= 1'b0;
         cnt           <= '0;
      end else if (in != cand) begin
         cand <= in;
         cnt  <= '0;
      end else if (cnt != LAST)
         cnt <= cnt + 1'b1;
      else
         stable_pushed <= cand[2];
endmodule

// File: rtl/heading_ctrl.sv
// heading_ctrl: filters presses into turns, queues up to two, commits one per step
module heading_ctrl
   import wormy_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES = 250000,
   parameter int         CNT_W           = $clog2(DEBOUNCE_CYCLES),
   parameter logic [1:0] INIT_DIR        = DIR_RIGHT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       button_pushed,
   input  logic [1:0] button_state,
   input  logic       step,
   output logic [1:0] heading,
   output logic       turned,
   output logic       rejected,
   output logic       overflow,
   output logic [1:0] queue_count
);
   logic       press;
   logic [1:0] press_dir;
   logic [1:0] q0, q1;
   logic [1:0] ref_dir, cnt_after, n_q0, n_q1;
   logic       deq, rej, enq, ovf;

   heading_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .pushed   (button_pushed),
      .state    (button_state),
      .press    (press),
      .press_dir(press_dir)
   );

   // Filter against the pre-edge tail, then shift/insert into the two-entry FIFO
   always_comb begin
      ref_dir   = (queue_count == 2'd0) ? heading : (queue_count == 2'd1) ? q0 : q1;
      deq       = step && (queue_count != 2'd0);
      rej       = press && ((press_dir == ref_dir) || is_opposite(press_dir, ref_dir));
      cnt_after = queue_count - {1'b0, deq};
      enq       = press && !rej && (cnt_after != 2'd2);
      ovf       = press && !rej && (cnt_after == 2'd2);
      n_q0      = (enq && cnt_after == 2'd0) ? press_dir : deq ? q1 : q0;
      n_q1      = (enq && cnt_after == 2'd1) ? press_dir : q1;
   end

   // Commit heading on step and register the event pulses
   always_ff @(posedge clk)
      if (!rst_n) begin
         heading     <= INIT_DIR;
         q0          <= '0;
         q1          <= '0;
         queue_count <= '0;
         turned      <= 1'b0;
         rejected    <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         heading     <= deq ? q0 : heading;
         q0          <= n_q0;
         q1          <= n_q1;
         queue_count <= cnt_after + {1'b0, enq};
         turned      <= deq;
         rejected    <= rej;
         overflow    <= ovf;
      end
endmodule
